eth_axi_regs: RTL and testbench

AXI4-Lite responder (slave) register file for the Ethernet subsystem. It terminates the PS M_AXI_0 general-purpose master and exposes control, MDIO command and scratch registers to the Ethernet and MDIO logic. It also returns status captured from those blocks. Single clock domain (AXI_Clk). One outstanding write and one outstanding read at a time.

---
 rtl/eth_axi_regs.sv | 205 ++++++++++++++++++++
 tb/tb_eth_axi_regs.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_axi_regs.sv
// AXI4-Lite register file for the Ethernet subsystem: control, MDIO command/data,
// scratch and status registers, with one outstanding write and one outstanding read.
module eth_axi_regs #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter logic [31:0] VERSION    = 32'h0001_0000
) (
    input  logic        AXI_Clk,
    input  logic        AXI_Rstn,
    input  logic        AXI_awvalid,
    output logic        AXI_awready,
    input  logic [31:0] AXI_awaddr,
    input  logic        AXI_wvalid,
    output logic        AXI_wready,
    input  logic [31:0] AXI_wdata,
    input  logic [3:0]  AXI_wstrb,
    output logic        AXI_bvalid,
    output logic [1:0]  AXI_bresp,
    input  logic        AXI_bready,
    input  logic        AXI_arvalid,
    output logic        AXI_arready,
    input  logic [31:0] AXI_araddr,
    output logic        AXI_rvalid,
    output logic [31:0] AXI_rdata,
    output logic [1:0]  AXI_rresp,
    input  logic        AXI_rready,
    output logic [31:0] Ctrl_Reg,
    output logic [31:0] Mdio_Cmd_Reg,
    output logic [15:0] Mdio_Wdata_Reg,
    output logic        Mdio_Start,
    input  logic [15:0] Mdio_Rdata,
    input  logic [31:0] Status
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDX_CTRL       = 3'd0,
        IDX_MDIO_CMD   = 3'd1,
        IDX_MDIO_WDATA = 3'd2,
        IDX_MDIO_RDATA = 3'd3,
        IDX_STATUS     = 3'd4,
        IDX_SCRATCH    = 3'd5,
        IDX_VERSION    = 3'd6,
        IDX_MDIO_GO    = 3'd7
    } reg_idx_e;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_beat_t;

    // Write-channel capture
    logic                  aw_hold;
    logic                  w_hold;
    logic [ADDR_WIDTH-1:2] aw_addr_q;
    wr_beat_t              w_beat_q;

    logic [31:0] ctrl_q;
    logic [31:0] mdio_cmd_q;
    logic [15:0] mdio_wdata_q;
    logic [31:0] scratch_q;

    logic        aw_hs, w_hs, ar_hs, commit;
    logic        wr_oor, wr_writable, wr_ok;
    reg_idx_e    wr_idx;
    logic [31:0] ctrl_m, mdio_cmd_m, mdio_wdata_m, scratch_m;
    logic        rd_oor;
    reg_idx_e    rd_idx;
    logic [31:0] rd_val;
    logic        rd_known;

    // Bits the decoder never looks at.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{AXI_awaddr[31:ADDR_WIDTH], AXI_awaddr[1:0],
                                AXI_araddr[31:ADDR_WIDTH], AXI_araddr[1:0]};

    function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                                input logic [31:0] data,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old;
        for (int i = 0; i < 4; i++)
            if (strb[i]) res[8*i +: 8] = data[8*i +: 8];
        return res;
    endfunction

    assign AXI_awready = !aw_hold && !AXI_bvalid;
    assign AXI_wready  = !w_hold && !AXI_bvalid;
    assign AXI_arready = !AXI_rvalid;

    assign aw_hs  = AXI_awvalid && AXI_awready;
    assign w_hs   = AXI_wvalid && AXI_wready;
    assign ar_hs  = AXI_arvalid && AXI_arready;
    assign commit = aw_hold && w_hold;

    assign wr_oor = |aw_addr_q[ADDR_WIDTH-1:5];
    assign wr_idx = reg_idx_e'(aw_addr_q[4:2]);

    always_comb begin
        wr_writable = 1'b0;
        case (wr_idx)
            IDX_CTRL, IDX_MDIO_CMD, IDX_MDIO_WDATA,
            IDX_SCRATCH, IDX_MDIO_GO: wr_writable = 1'b1;
            default:                  wr_writable = 1'b0;
        endcase
    end

    assign wr_ok = !wr_oor && wr_writable;

    always_comb begin
        ctrl_m       = merge_bytes(ctrl_q, w_beat_q.data, w_beat_q.strb);
        mdio_cmd_m   = merge_bytes(mdio_cmd_q, w_beat_q.data, w_beat_q.strb);
        mdio_wdata_m = merge_bytes({16'h0, mdio_wdata_q}, w_beat_q.data, w_beat_q.strb);
        scratch_m    = merge_bytes(scratch_q, w_beat_q.data, w_beat_q.strb);
    end

    always_ff @(posedge AXI_Clk or negedge AXI_Rstn) begin
        if (!AXI_Rstn) begin
            aw_hold    <= 1'b0;
            w_hold     <= 1'b0;
            aw_addr_q  <= '0;
            w_beat_q   <= '0;
            AXI_bvalid <= 1'b0;
            AXI_bresp  <= RESP_OKAY;
            Mdio_Start <= 1'b0;
        end else begin
            Mdio_Start <= 1'b0;
            if (aw_hs) begin
                aw_hold   <= 1'b1;
                aw_addr_q <= AXI_awaddr[ADDR_WIDTH-1:2];
            end
            if (w_hs) begin
                w_hold   <= 1'b1;
                w_beat_q <= '{data: AXI_wdata, strb: AXI_wstrb};
            end
            if (commit) begin
                aw_hold    <= 1'b0;
                w_hold     <= 1'b0;
                AXI_bvalid <= 1'b1;
                AXI_bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                Mdio_Start <= wr_ok && (wr_idx == IDX_MDIO_GO) &&
                              w_beat_q.strb[0] && w_beat_q.data[0];
            end else if (AXI_bvalid && AXI_bready) begin
                AXI_bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge AXI_Clk or negedge AXI_Rstn) begin
        if (!AXI_Rstn) begin
            ctrl_q       <= '0;
            mdio_cmd_q   <= '0;
            mdio_wdata_q <= '0;
            scratch_q    <= '0;
        end else if (commit && wr_ok) begin
            case (wr_idx)
                IDX_CTRL:       ctrl_q       <= ctrl_m;
                IDX_MDIO_CMD:   mdio_cmd_q   <= mdio_cmd_m;
                IDX_MDIO_WDATA: mdio_wdata_q <= mdio_wdata_m[15:0];
                IDX_SCRATCH:    scratch_q    <= scratch_m;
                default:        ;
            endcase
        end
    end

    // Read mux samples pre-commit register values, so a read on a commit edge sees old data.
    assign rd_oor = |AXI_araddr[ADDR_WIDTH-1:5];
    assign rd_idx = reg_idx_e'(AXI_araddr[4:2]);

    always_comb begin
        rd_val   = '0;
        rd_known = 1'b1;
        case (rd_idx)
            IDX_CTRL:       rd_val = ctrl_q;
            IDX_MDIO_CMD:   rd_val = mdio_cmd_q;
            IDX_MDIO_WDATA: rd_val = {16'h0, mdio_wdata_q};
            IDX_MDIO_RDATA: rd_val = {16'h0, Mdio_Rdata};
            IDX_STATUS:     rd_val = Status;
            IDX_SCRATCH:    rd_val = scratch_q;
            IDX_VERSION:    rd_val = VERSION;
            IDX_MDIO_GO:    rd_val = '0;
            default:        rd_known = 1'b0;
        endcase
    end

    always_ff @(posedge AXI_Clk or negedge AXI_Rstn) begin
        if (!AXI_Rstn) begin
            AXI_rvalid <= 1'b0;
            AXI_rdata  <= '0;
            AXI_rresp  <= RESP_OKAY;
        end else if (ar_hs) begin
            AXI_rvalid <= 1'b1;
            AXI_rdata  <= (rd_oor || !rd_known) ? 32'h0 : rd_val;
            AXI_rresp  <= (rd_oor || !rd_known) ? RESP_SLVERR : RESP_OKAY;
        end else if (AXI_rvalid && AXI_rready) begin
            AXI_rvalid <= 1'b0;
        end
    end

    assign Ctrl_Reg       = ctrl_q;
    assign Mdio_Cmd_Reg   = mdio_cmd_q;
    assign Mdio_Wdata_Reg = mdio_wdata_q;

endmodule

// File: tb/tb_eth_axi_regs.sv
// Directed bench for eth_axi_regs: inputs driven and outputs sampled on the falling edge.
`timescale 1ns/1ps
module tb_eth_axi_regs;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic [31:0] awaddr = 0, wdata = 0, araddr = 0;
    logic [3:0]  wstrb = 0;
    logic        awready, wready, bvalid, arready, rvalid, mdio_start;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata, ctrl_reg, mdio_cmd_reg;
    logic [15:0] mdio_wdata_reg;
    logic [15:0] mdio_rdata = 16'hBEEF;
    logic [31:0] status = 32'hA5A5_1234;

    int total = 0;
    int bad = 0;
    int start_cnt = 0;
    int bhs_cnt = 0;

    always #5 clk = ~clk;

    eth_axi_regs dut (
        .AXI_Clk(clk), .AXI_Rstn(rstn),
        .AXI_awvalid(awvalid), .AXI_awready(awready), .AXI_awaddr(awaddr),
        .AXI_wvalid(wvalid), .AXI_wready(wready), .AXI_wdata(wdata), .AXI_wstrb(wstrb),
        .AXI_bvalid(bvalid), .AXI_bresp(bresp), .AXI_bready(bready),
        .AXI_arvalid(arvalid), .AXI_arready(arready), .AXI_araddr(araddr),
        .AXI_rvalid(rvalid), .AXI_rdata(rdata), .AXI_rresp(rresp), .AXI_rready(rready),
        .Ctrl_Reg(ctrl_reg), .Mdio_Cmd_Reg(mdio_cmd_reg), .Mdio_Wdata_Reg(mdio_wdata_reg),
        .Mdio_Start(mdio_start), .Mdio_Rdata(mdio_rdata), .Status(status)
    );

    always @(negedge clk) if (mdio_start === 1'b1) start_cnt++;
    always @(posedge clk) if (rstn && bvalid === 1'b1 && bready === 1'b1) bhs_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Simultaneous AW+W; returns the response and Mdio_Start seen alongside bvalid.
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [1:0] r, output logic st);
        @(negedge clk);
        check("wr_awready", awready, 1);
        awvalid = 1; awaddr = a; wvalid = 1; wdata = d; wstrb = s; bready = 1;
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        check("wr_b_latency", bvalid, 0);
        @(negedge clk);
        check("wr_bvalid", bvalid, 1);
        r = bresp; st = mdio_start;
        @(negedge clk);
        check("wr_bvalid_clr", bvalid, 0);
        bready = 0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        @(negedge clk);
        check("rd_arready", arready, 1);
        arvalid = 1; araddr = a; rready = 0;
        @(negedge clk);
        arvalid = 0;
        check("rd_rvalid", rvalid, 1);
        d = rdata; r = rresp; rready = 1;
        @(negedge clk);
        rready = 0;
        check("rd_rvalid_clr", rvalid, 0);
    endtask

    initial begin
        logic [1:0]  r;
        logic        st;
        logic [31:0] d;
        int          s0, b0;

        // Reset state
        #12;
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_ctrl", ctrl_reg, 0);
        @(negedge clk); rstn = 1;
        @(negedge clk);
        check("rst_awready", awready, 1);
        check("rst_wready", wready, 1);
        check("rst_arready", arready, 1);

        // 1: simultaneous write to SCRATCH then read back
        wr(32'h14, 32'hDEADBEEF, 4'hF, r, st);
        check("t1_bresp", r, 2'b00);
        rd(32'h14, d, r);
        check("t1_rdata", d, 32'hDEADBEEF);
        check("t1_rresp", r, 2'b00);

        // Read on the commit edge sees the pre-commit value
        @(negedge clk);
        awvalid = 1; awaddr = 32'h14; wvalid = 1; wdata = 32'hCAFEF00D; wstrb = 4'hF; bready = 1;
        @(negedge clk);
        awvalid = 0; wvalid = 0; arvalid = 1; araddr = 32'h14; rready = 0;
        @(negedge clk);
        arvalid = 0;
        check("same_edge_rvalid", rvalid, 1);
        check("same_edge_rdata_old", rdata, 32'hDEADBEEF);
        check("same_edge_bvalid", bvalid, 1);
        rready = 1;
        @(negedge clk);
        rready = 0; bready = 0;
        rd(32'h14, d, r);
        check("same_edge_rdata_new", d, 32'hCAFEF00D);

        // 2: W three cycles before AW, partial strobes
        b0 = bhs_cnt;
        @(negedge clk);
        wvalid = 1; wdata = 32'h12345678; wstrb = 4'b0101; bready = 1;
        @(negedge clk);
        wvalid = 0;
        check("t2_wready_held", wready, 0);
        check("t2_awready_open", awready, 1);
        @(negedge clk);
        @(negedge clk);
        check("t2_no_commit", bvalid, 0);
        awvalid = 1; awaddr = 32'h00;
        @(negedge clk);
        awvalid = 0;
        check("t2_b_latency", bvalid, 0);
        @(negedge clk);
        check("t2_bvalid", bvalid, 1);
        check("t2_bresp", bresp, 2'b00);
        repeat (4) @(negedge clk);
        bready = 0;
        check("t2_ctrl", ctrl_reg, 32'h00340078);
        check("t2_one_bresp", bhs_cnt - b0, 1);

        // 3: MDIO_GO pulse
        s0 = start_cnt;
        wr(32'h1C, 32'h1, 4'hF, r, st);
        check("t3_go_bresp", r, 2'b00);
        check("t3_go_with_bvalid", st, 1);
        check("t3_go_cycles", start_cnt - s0, 1);
        s0 = start_cnt;
        wr(32'h1C, 32'h0, 4'hF, r, st);
        check("t3_nogo_pulse", start_cnt - s0, 0);
        wr(32'h1C, 32'h1, 4'b1110, r, st);
        check("t3_nostrb_pulse", start_cnt - s0, 0);
        rd(32'h1C, d, r);
        check("t3_go_reads0", d, 0);

        // 4: out-of-range and read-only accesses; other registers
        wr(32'h40, 32'hFFFFFFFF, 4'hF, r, st);
        check("t4_oor_bresp", r, 2'b10);
        wr(32'h54, 32'h11111111, 4'hF, r, st);
        check("t4_oor_alias_bresp", r, 2'b10);
        wr(32'h10, 32'hFFFFFFFF, 4'hF, r, st);
        check("t4_ro_status_bresp", r, 2'b10);
        wr(32'h18, 32'hFFFFFFFF, 4'hF, r, st);
        check("t4_ro_version_bresp", r, 2'b10);
        check("t4_ctrl_kept", ctrl_reg, 32'h00340078);
        rd(32'h14, d, r);
        check("t4_scratch_kept", d, 32'hCAFEF00D);
        rd(32'h40, d, r);
        check("t4_oor_rresp", r, 2'b10);
        check("t4_oor_rdata", d, 0);
        rd(32'h10, d, r);
        check("t4_status", d, 32'hA5A5_1234);
        rd(32'h18, d, r);
        check("t4_version", d, 32'h0001_0000);
        rd(32'h0C, d, r);
        check("t4_mdio_rdata", d, 32'h0000BEEF);
        wr(32'h08, 32'hFFFFFFFF, 4'hF, r, st);
        check("t4_wdata_port", mdio_wdata_reg, 16'hFFFF);
        rd(32'h0B, d, r);
        check("t4_wdata_upper0", d, 32'h0000FFFF);

        // 5: bready held low stalls the write channel
        @(negedge clk);
        awvalid = 1; awaddr = 32'h04; wvalid = 1; wdata = 32'h421; wstrb = 4'hF; bready = 0;
        @(negedge clk);
        awaddr = 32'h00; wdata = 32'hAAAA5555;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5_bvalid_held", bvalid, 1);
            check("t5_aw_stall", {awready, wready}, 2'b00);
        end
        check("t5_ctrl_waits", ctrl_reg, 32'h00340078);
        bready = 1;
        @(negedge clk);
        check("t5_bvalid_clr", bvalid, 0);
        check("t5_awready_back", awready, 1);
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        @(negedge clk);
        check("t5_second_bvalid", bvalid, 1);
        check("t5_ctrl_new", ctrl_reg, 32'hAAAA5555);
        check("t5_cmd", mdio_cmd_reg, 32'h421);
        @(negedge clk);
        bready = 0;

        // 5b: rready held low stalls the read channel
        arvalid = 1; araddr = 32'h0C; rready = 0;
        @(negedge clk);
        araddr = 32'h18;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5_rvalid_held", rvalid, 1);
            check("t5_arready_low", arready, 0);
            check("t5_rdata_held", rdata, 32'h0000BEEF);
        end
        rready = 1;
        @(negedge clk);
        check("t5_rvalid_clr", rvalid, 0);
        check("t5_arready_back", arready, 1);
        @(negedge clk);
        arvalid = 0;
        check("t5_b2b_rvalid", rvalid, 1);
        check("t5_b2b_rdata", rdata, 32'h0001_0000);
        @(negedge clk);
        check("t5_b2b_clr", rvalid, 0);
        rready = 0;

        // 6: reset mid-transaction
        @(negedge clk);
        awvalid = 1; awaddr = 32'h14;
        @(negedge clk);
        awvalid = 0;
        check("t6_aw_held", awready, 0);
        #1 rstn = 0;
        #1;
        check("t6_bvalid", bvalid, 0);
        check("t6_rvalid", rvalid, 0);
        check("t6_ctrl", ctrl_reg, 0);
        check("t6_cmd", mdio_cmd_reg, 0);
        check("t6_wdata", mdio_wdata_reg, 0);
        check("t6_rdata", rdata, 0);
        @(negedge clk); rstn = 1;
        @(negedge clk);
        check("t6_readies", {awready, wready, arready}, 3'b111);
        wvalid = 1; wdata = 32'h55; wstrb = 4'hF; bready = 1;
        @(negedge clk);
        wvalid = 0;
        repeat (4) @(negedge clk);
        check("t6_w_alone_no_b", bvalid, 0);
        bready = 0;
        rd(32'h14, d, r);
        check("t6_scratch_zero", d, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
